// File: rtl/core_dmem_if.sv
// Pipelined Wishbone bundle shared by the data memory and its masters.
//   cyc, stb, we    : cycle, strobe, write-enable (master -> slave)
//   adr, sel        : byte address and byte-lane enables (master -> slave)
//   dat_si          : write data (master -> slave)
//   dat_so          : read data (slave -> master)
//   ack, stall      : acknowledge and back-pressure (slave -> master)
interface wishbone;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_si;
    logic [31:0] dat_so;
    logic        ack;
    logic        stall;

    modport pl_slave (
        input  cyc, stb, we, adr, sel, dat_si,
        output dat_so, ack, stall
    );

    modport pl_master (
        output cyc, stb, we, adr, sel, dat_si,
        input  dat_so, ack, stall
    );
endinterface

// File: rtl/core_dmem.sv
// Core data memory: DEPTH x 32-bit words behind a pipelined Wishbone slave,
// with WAIT_STATES extra stalled cycles per access.
//   clk  : single clock, all state changes on posedge
//   rst  : synchronous active-high reset (memory contents are kept)
//   bus  : wishbone.pl_slave (cyc/stb/we/adr/sel/dat_si in, dat_so/ack/stall out)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no access outstanding, ready to accept
// WAIT  | access accepted, stalling while the wait counter runs down
// RESP  | ack cycle for the outstanding access; may accept the next one
module core_dmem #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic      clk,
    input logic      rst,
    wishbone.pl_slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [2:0]  WS = 3'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [2:0]    wait_cnt;
    logic          ack_q;
    logic          stall_q;
    logic [31:0]   dat_q;
    logic [31:0]   rd_hold;
    logic          rd_pend;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic [31:0]   mem_rd;
    logic          accept;
    logic          unused_adr;

    assign idx        = bus.adr[AW+1:2];
    assign mem_rd     = mem[idx];
    assign accept     = bus.cyc & bus.stb & ~stall_q & ~rst;
    assign unused_adr = ^{bus.adr[31:AW+2], bus.adr[1:0]};

    assign bus.ack    = ack_q;
    assign bus.stall  = stall_q;
    assign bus.dat_so = dat_q;

    // Memory has no reset; a write lands at the end of its acceptance cycle,
    // so any later access (including one in the ack cycle) sees it.
    always_ff @(posedge clk) begin
        if (accept && bus.we) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.sel[i]) begin
                    mem[idx][8*i +: 8] <= bus.dat_si[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            ack_q    <= 1'b0;
            stall_q  <= 1'b0;
            dat_q    <= 32'h0;
            rd_hold  <= 32'h0;
            rd_pend  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        rd_pend <= ~bus.we;
                        rd_hold <= mem_rd;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                            ack_q <= 1'b1;
                            if (!bus.we) begin
                                dat_q <= mem_rd;
                            end
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WS;
                            stall_q  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    // Dropping cyc mid-wait abandons the access; a write has
                    // already been committed and stays.
                    if (!bus.cyc) begin
                        state    <= IDLE;
                        stall_q  <= 1'b0;
                        wait_cnt <= 3'd0;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                        if (wait_cnt == 3'd1) begin
                            state   <= RESP;
                            stall_q <= 1'b0;
                            ack_q   <= 1'b1;
                            if (rd_pend) begin
                                dat_q <= rd_hold;
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/core_dmem.md
CORE_DMEM -- requirements
Module: core_dmem

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, memory size in 32-bit words (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_STATES, default 0, extra busy cycles per access (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port bus  wishbone.pl_slave  -  pipelined Wishbone slave end, carrying the signals in REQ-006..REQ-013.
REQ-006 SHALL have bus.cyc  input  1  bus cycle in progress.
REQ-007 SHALL have bus.stb  input  1  request strobe.
REQ-008 SHALL have bus.we  input  1  1 = write, 0 = read.
REQ-009 SHALL have bus.adr  input  32  byte address; word index = adr[log2(DEPTH)+1:2].
REQ-010 SHALL have bus.sel  input  4  byte-lane enables; sel[i] covers data bits 8i+7:8i.
REQ-011 SHALL have bus.dat_si  input  32  write data.
REQ-012 SHALL have bus.dat_so, bus.ack, bus.stall  outputs  32/1/1  read data, acknowledge, stall.

Function
REQ-013 SHALL accept a request in cycle N only when cyc=1, stb=1 and stall=0 in that cycle.
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; IDLE->WAIT on accept with WAIT_STATES>0; IDLE->RESP on accept with WAIT_STATES=0; WAIT->RESP when wait counter reaches 0; RESP->IDLE with no new accept, RESP->WAIT/RESP on a new accept, as from IDLE.
REQ-015 SHALL load a 3-bit wait counter with WAIT_STATES on accept and decrement it once per cycle in WAIT.
REQ-016 SHALL assert ack for exactly one cycle, N+1+WAIT_STATES, for a request accepted in cycle N, in acceptance order.
REQ-017 SHALL drive stall=1 in cycles N+1..N+WAIT_STATES and stall=0 in IDLE and RESP; WAIT_STATES=0 therefore gives one accept per cycle.
REQ-018 SHALL commit a write at the end of acceptance cycle N, updating only lanes with sel[i]=1; sel=0 writes nothing and is still acked.
REQ-019 SHALL capture read data from the word addressed in cycle N, with the write committed in that cycle already visible, and drive it on dat_so in the ack cycle.
REQ-020 SHALL hold dat_so unchanged in non-ack cycles and in write-ack cycles.
REQ-021 SHALL ignore adr[1:0] and adr bits above the index; addresses wrap modulo DEPTH words.
REQ-022 SHALL, when cyc=0 while in WAIT, abort: return to IDLE, suppress the pending ack and keep any committed write.
REQ-023 SHALL ignore stb while cyc=0 and ignore stb while stall=1 (no accept, no ack).
REQ-024 SHALL let a read accepted in the ack cycle of a preceding write to the same word return the written data.

Reset
REQ-025 SHALL, with rst=1 at a posedge, force state IDLE, counter 0, ack=0, stall=0, dat_so=32'h0, including mid-access, dropping any pending ack.
REQ-026 SHALL NOT clear memory contents on reset.
REQ-027 SHALL ignore bus requests in any cycle where rst=1.

Verification
REQ-028 WAIT_STATES=0: write 32'hDEADBEEF to adr 32'h10 (sel=4'hF) in cycle 0, read adr 32'h10 in cycle 1 -> ack in cycles 1 and 2, dat_so=32'hDEADBEEF in cycle 2, stall always 0.
REQ-029 WAIT_STATES=3: read accepted in cycle 0 -> stall=1 in cycles 1-3, ack=1 only in cycle 4, next request accepted in cycle 4.
REQ-030 Byte lanes: word holds 32'h11223344; write 32'hAABBCCDD with sel=4'b0101 -> readback 32'h11BB33DD.
REQ-031 Wrap: DEPTH=1024, write 32'h5 to adr 32'h0, read adr 32'h1000 -> dat_so=32'h5.
REQ-032 Abort: WAIT_STATES=2, write accepted in cycle 0, cyc=0 in cycle 1 -> no ack in cycles 1-4; later read of same word returns the written data.
REQ-033 Reset: WAIT_STATES=4, rst=1 in cycle 2 after an accept in cycle 0 -> from cycle 3 ack=0, stall=0, dat_so=0; memory contents preserved.
